prod_accumulator: RTL

PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

---
 rtl/prod_accumulator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/prod_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : prod_accumulator
//  Description : Accumulates a programmable number of unsigned products from
//                an upstream multiplier, then presents the sum through a
//                valid/ready handshake.
//
//  Ports
//    clk        in   1        single clock, rising-edge
//    rst_n      in   1        asynchronous active-low reset
//    start      in   1        begin a new accumulation (accepted in IDLE only)
//    len        in   8        number of products, latched when start is taken
//    abort      in   1        cancel an accumulation in progress
//    prod_in    in   PROD_W   unsigned product
//    prod_valid in   1        qualifies prod_in
//    prod_ready out  1        high while accumulating
//    acc_out    out  ACC_W    accumulated sum (modulo 2^ACC_W)
//    acc_valid  out  1        qualifies acc_out
//    acc_ready  in   1        downstream accept
//    ovf        out  1        sticky carry-out flag for the current run
//    busy       out  1        high whenever not IDLE
//
//  Revision    : 1.0  initial release
// ============================================================================
module prod_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic              abort,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ACC_W-1:0]   r_acc;
    logic [7:0]         r_len;
    logic [7:0]         r_cnt;
    logic               r_ovf;

    logic               w_start_ok;
    logic               w_beat;
    logic               w_last;
    logic [ACC_W:0]     w_sum;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};

    assign w_start_ok = (r_state == ST_IDLE) && start && (len != 8'd0);

    // abort wins over a beat presented in the same cycle, so the beat is
    // neither summed nor counted.
    assign w_beat     = (r_state == ST_ACCUM) && prod_valid && !abort;

    // The count never exceeds len (<= 255), so the 8-bit increment cannot wrap
    // before the comparison matches.
    assign w_last     = w_beat && ((r_cnt + 8'd1) == r_len);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (acc_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator, beat counter, latched length, overflow flag.
    // The accumulator doubles as the output register, so the final sum is
    // visible in the cycle after the last beat and holds through DONE and
    // the following IDLE period until the next accepted start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_len <= 8'd0;
            r_cnt <= 8'd0;
            r_ovf <= 1'b0;
        end else if (w_start_ok) begin
            r_acc <= '0;
            r_len <= len;
            r_cnt <= 8'd0;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_cnt <= r_cnt + 8'd1;
            if (w_sum[ACC_W]) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign prod_ready = (r_state == ST_ACCUM);
    assign acc_valid  = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);
    assign acc_out    = r_acc;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire
